// File: rtl/pio_fifo_pair.sv
// TX/RX FIFO pair for one PIO state machine.
// TX: system pushes, machine pulls. RX: machine pushes, system pulls.
// Both directions share 2*DEPTH words of storage split into halves A and B.
// The join mode can lend one direction's half to the other.
// The mode input is named join_mode because "join" is a reserved word.
module pio_fifo_pair #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(2*DEPTH)+1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       join_mode,
  input  logic             flush,
  input  logic             tx_push,
  input  logic [WIDTH-1:0] tx_din,
  input  logic             tx_pull,
  output logic [WIDTH-1:0] tx_dout,
  output logic             tx_empty,
  output logic             tx_full,
  output logic [LW-1:0]    tx_level,
  input  logic             rx_push,
  input  logic [WIDTH-1:0] rx_din,
  input  logic             rx_pull,
  output logic [WIDTH-1:0] rx_dout,
  output logic             rx_empty,
  output logic             rx_full,
  output logic [LW-1:0]    rx_level,
  output logic [3:0]       err,
  input  logic [3:0]       err_clr
);

  localparam int AW = $clog2(2*DEPTH);
  localparam logic [LW-1:0] CAP_ONE = LW'(DEPTH);
  localparam logic [LW-1:0] CAP_TWO = LW'(2*DEPTH);

  typedef enum logic [1:0] {
    MODE_NONE = 2'd0,
    MODE_JTX  = 2'd1,
    MODE_JRX  = 2'd2
  } mode_t;

  mode_t mode, mode_q;

  logic [WIDTH-1:0] mem [2*DEPTH];

  logic [AW-1:0] tx_head, tx_tail, rx_head, rx_tail;
  logic [LW-1:0] tx_lvl, rx_lvl;
  logic [LW-1:0] tx_cap, rx_cap;
  logic [AW-1:0] rx_base;
  logic [AW-1:0] rx_raddr, rx_waddr;

  logic flush_now;
  logic tx_pull_ok, tx_push_ok, rx_pull_ok, rx_push_ok;
  logic [3:0] err_set;

  // Pointers wrap at the active capacity of their direction.
  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p,
                                             input logic [LW-1:0] cap);
    if ({1'b0, p} == cap - LW'(1))
      return '0;
    else
      return p + AW'(1);
  endfunction

  // Decode the join input; the reserved code behaves as unjoined.
  always_comb begin
    mode = MODE_NONE;
    case (join_mode)
      2'd1:    mode = MODE_JTX;
      2'd2:    mode = MODE_JRX;
      default: mode = MODE_NONE;
    endcase
  end

  // Capacity and storage base of each direction for the current mode.
  always_comb begin
    tx_cap  = CAP_ONE;
    rx_cap  = CAP_ONE;
    rx_base = AW'(DEPTH);
    case (mode)
      MODE_JTX: begin
        tx_cap = CAP_TWO;
        rx_cap = '0;
      end
      MODE_JRX: begin
        tx_cap  = '0;
        rx_cap  = CAP_TWO;
        rx_base = '0;
      end
      default: ;
    endcase
  end

  assign rx_raddr = rx_base + rx_head;
  assign rx_waddr = rx_base + rx_tail;

  assign tx_level = tx_lvl;
  assign rx_level = rx_lvl;
  assign tx_empty = (tx_lvl == '0);
  assign rx_empty = (rx_lvl == '0);
  assign tx_full  = (tx_lvl == tx_cap);
  assign rx_full  = (rx_lvl == rx_cap);

  assign tx_dout = tx_empty ? '0 : mem[tx_head];
  assign rx_dout = rx_empty ? '0 : mem[rx_raddr];

  // A join change or flush empties both sides and swallows that cycle's traffic.
  assign flush_now = flush || (mode != mode_q);

  // A full FIFO still accepts a push when a pull frees a slot in the same cycle.
  assign tx_pull_ok = tx_pull && !tx_empty;
  assign rx_pull_ok = rx_pull && !rx_empty;
  assign tx_push_ok = tx_push && (!tx_full || tx_pull_ok);
  assign rx_push_ok = rx_push && (!rx_full || rx_pull_ok);

  assign err_set = flush_now ? 4'b0000 :
                   {rx_pull && rx_empty, rx_push && !rx_push_ok,
                    tx_pull && tx_empty, tx_push && !tx_push_ok};

  // Pointer, level, mode and sticky error state.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= MODE_NONE;
      tx_head <= '0;
      tx_tail <= '0;
      tx_lvl  <= '0;
      rx_head <= '0;
      rx_tail <= '0;
      rx_lvl  <= '0;
      err     <= '0;
    end else begin
      mode_q <= mode;
      err    <= (err & ~err_clr) | err_set;
      if (flush_now) begin
        tx_head <= '0;
        tx_tail <= '0;
        tx_lvl  <= '0;
        rx_head <= '0;
        rx_tail <= '0;
        rx_lvl  <= '0;
      end else begin
        if (tx_push_ok) tx_tail <= ptr_next(tx_tail, tx_cap);
        if (tx_pull_ok) tx_head <= ptr_next(tx_head, tx_cap);
        tx_lvl <= tx_lvl + LW'(tx_push_ok) - LW'(tx_pull_ok);
        if (rx_push_ok) rx_tail <= ptr_next(rx_tail, rx_cap);
        if (rx_pull_ok) rx_head <= ptr_next(rx_head, rx_cap);
        rx_lvl <= rx_lvl + LW'(rx_push_ok) - LW'(rx_pull_ok);
      end
    end
  end

  // Storage writes; in a joined mode only the active side can accept a push.
  always_ff @(posedge clk) begin
    if (!reset && !flush_now) begin
      if (tx_push_ok) mem[tx_tail] <= tx_din;
      if (rx_push_ok) mem[rx_waddr] <= rx_din;
    end
  end

endmodule

// File: tb/tb_pio_fifo_pair.sv
// Self-checking bench for pio_fifo_pair: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_pio_fifo_pair;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int LW = $clog2(2*D)+1;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    jm;
  logic          flush;
  logic          tx_push, tx_pull, rx_push, rx_pull;
  logic [W-1:0]  tx_din, rx_din;
  logic [W-1:0]  tx_dout, rx_dout;
  logic          tx_empty, tx_full, rx_empty, rx_full;
  logic [LW-1:0] tx_level, rx_level;
  logic [3:0]    err, err_clr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pio_fifo_pair #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .join_mode(jm), .flush(flush),
    .tx_push(tx_push), .tx_din(tx_din), .tx_pull(tx_pull), .tx_dout(tx_dout),
    .tx_empty(tx_empty), .tx_full(tx_full), .tx_level(tx_level),
    .rx_push(rx_push), .rx_din(rx_din), .rx_pull(rx_pull), .rx_dout(rx_dout),
    .rx_empty(rx_empty), .rx_full(rx_full), .rx_level(rx_level),
    .err(err), .err_clr(err_clr)
  );

  // Reference model: plain queues, capacity from the mode rules.
  logic [W-1:0] tx_q[$];
  logic [W-1:0] rx_q[$];
  logic [3:0]   m_err = 4'b0000;
  int           m_mode_q = 0;

  function automatic int effMode(input logic [1:0] j);
    return (j == 2'd3) ? 0 : int'(j);
  endfunction

  function automatic int capOf(input int mode, input bit is_tx);
    if (mode == 1) return is_tx ? 2*D : 0;
    if (mode == 2) return is_tx ? 0 : 2*D;
    return D;
  endfunction

  task automatic modelStep();
    int  mode;
    bit  pull_ok, push_ok;
    logic [3:0] set;
    mode = effMode(jm);
    set  = 4'b0000;
    if (reset) begin
      tx_q.delete();
      rx_q.delete();
      m_err    = 4'b0000;
      m_mode_q = 0;
    end else begin
      if (flush || mode != m_mode_q) begin
        tx_q.delete();
        rx_q.delete();
      end else begin
        pull_ok = tx_pull && tx_q.size() > 0;
        push_ok = tx_push && (tx_q.size() < capOf(mode, 1) || pull_ok);
        if (tx_pull && tx_q.size() == 0) set[1] = 1'b1;
        if (tx_push && !push_ok) set[0] = 1'b1;
        if (pull_ok) void'(tx_q.pop_front());
        if (push_ok) tx_q.push_back(tx_din);
        pull_ok = rx_pull && rx_q.size() > 0;
        push_ok = rx_push && (rx_q.size() < capOf(mode, 0) || pull_ok);
        if (rx_pull && rx_q.size() == 0) set[3] = 1'b1;
        if (rx_push && !push_ok) set[2] = 1'b1;
        if (pull_ok) void'(rx_q.pop_front());
        if (push_ok) rx_q.push_back(rx_din);
      end
      m_err    = (m_err & ~err_clr) | set;
      m_mode_q = mode;
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, sample after it.
  task automatic applyStimulus(input logic r, input logic [1:0] j, input logic f,
                               input logic tp, input logic [W-1:0] td, input logic tl,
                               input logic rp, input logic [W-1:0] rd, input logic rl,
                               input logic [3:0] c);
    @(negedge clk);
    reset = r; jm = j; flush = f;
    tx_push = tp; tx_din = td; tx_pull = tl;
    rx_push = rp; rx_din = rd; rx_pull = rl;
    err_clr = c;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic checkValue(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input int e_txl, input int e_rxl,
                             input logic [W-1:0] e_txd, input logic [W-1:0] e_rxd,
                             input logic [3:0] e_err, input logic e_txf, input logic e_txe,
                             input logic e_rxf, input logic e_rxe);
    checkValue({name, ".tx_level"}, W'(tx_level), W'(e_txl));
    checkValue({name, ".rx_level"}, W'(rx_level), W'(e_rxl));
    checkValue({name, ".tx_dout"}, tx_dout, e_txd);
    checkValue({name, ".rx_dout"}, rx_dout, e_rxd);
    checkValue({name, ".err"}, W'(err), W'(e_err));
    checkValue({name, ".tx_full"}, W'(tx_full), W'(e_txf));
    checkValue({name, ".tx_empty"}, W'(tx_empty), W'(e_txe));
    checkValue({name, ".rx_full"}, W'(rx_full), W'(e_rxf));
    checkValue({name, ".rx_empty"}, W'(rx_empty), W'(e_rxe));
  endtask

  task automatic checkModel(input string name);
    int mode;
    mode = effMode(jm);
    checkOutput(name, tx_q.size(), rx_q.size(),
                (tx_q.size() > 0) ? tx_q[0] : '0, (rx_q.size() > 0) ? rx_q[0] : '0,
                m_err, tx_q.size() == capOf(mode, 1), tx_q.size() == 0,
                rx_q.size() == capOf(mode, 0), rx_q.size() == 0);
  endtask

  typedef struct {
    logic [1:0] jm;  logic fl;
    logic txp; logic [W-1:0] txd; logic txl;
    logic rxp; logic [W-1:0] rxd; logic rxl;
    logic [3:0] clr;
    int etxl; int erxl; logic [W-1:0] etxd; logic [W-1:0] erxd; logic [3:0] eerr;
    logic etxf; logic etxe; logic erxf; logic erxe;
  } vec_t;

  vec_t vecs[$];

  task automatic addRow(input logic [1:0] j, input logic f, input logic tp, input logic [W-1:0] td,
                        input logic tl, input logic rp, input logic [W-1:0] rd, input logic rl,
                        input logic [3:0] c, input int etxl, input int erxl,
                        input logic [W-1:0] etxd, input logic [W-1:0] erxd, input logic [3:0] eerr,
                        input logic etxf, input logic etxe, input logic erxf, input logic erxe);
    vec_t v;
    v.jm = j; v.fl = f; v.txp = tp; v.txd = td; v.txl = tl;
    v.rxp = rp; v.rxd = rd; v.rxl = rl; v.clr = c;
    v.etxl = etxl; v.erxl = erxl; v.etxd = etxd; v.erxd = erxd; v.eerr = eerr;
    v.etxf = etxf; v.etxe = etxe; v.erxf = erxf; v.erxe = erxe;
    vecs.push_back(v);
  endtask

  initial begin
    // Overflow on the fifth push, then drain in order.
    addRow(0,0, 1,'h11,0, 0,0,0, 4'h0,  1,0,'h11,0,4'b0000, 0,0,0,1);
    addRow(0,0, 1,'h22,0, 0,0,0, 4'h0,  2,0,'h11,0,4'b0000, 0,0,0,1);
    addRow(0,0, 1,'h33,0, 0,0,0, 4'h0,  3,0,'h11,0,4'b0000, 0,0,0,1);
    addRow(0,0, 1,'h44,0, 0,0,0, 4'h0,  4,0,'h11,0,4'b0000, 1,0,0,1);
    addRow(0,0, 1,'h55,0, 0,0,0, 4'h0,  4,0,'h11,0,4'b0001, 1,0,0,1);
    addRow(0,0, 0,0,1,    0,0,0, 4'h0,  3,0,'h22,0,4'b0001, 0,0,0,1);
    addRow(0,0, 0,0,1,    0,0,0, 4'h0,  2,0,'h33,0,4'b0001, 0,0,0,1);
    addRow(0,0, 0,0,1,    0,0,0, 4'h0,  1,0,'h44,0,4'b0001, 0,0,0,1);
    addRow(0,0, 0,0,1,    0,0,0, 4'h0,  0,0,0,0,4'b0001,    0,1,0,1);
    // RX underflow, clear of a different bit, then set-wins-over-clear.
    addRow(0,0, 0,0,0,    0,0,1, 4'h1,  0,0,0,0,4'b1000,    0,1,0,1);
    addRow(0,0, 0,0,0,    0,0,1, 4'h8,  0,0,0,0,4'b1000,    0,1,0,1);
    addRow(0,0, 0,0,0,    0,0,0, 4'h8,  0,0,0,0,4'b0000,    0,1,0,1);
    // Full TX with simultaneous push and pull.
    addRow(0,0, 1,'hA1,0, 0,0,0, 4'h0,  1,0,'hA1,0,4'b0000, 0,0,0,1);
    addRow(0,0, 1,'hA2,0, 0,0,0, 4'h0,  2,0,'hA1,0,4'b0000, 0,0,0,1);
    addRow(0,0, 1,'hA3,0, 0,0,0, 4'h0,  3,0,'hA1,0,4'b0000, 0,0,0,1);
    addRow(0,0, 1,'hA4,0, 0,0,0, 4'h0,  4,0,'hA1,0,4'b0000, 1,0,0,1);
    addRow(0,0, 1,'hAA,1, 0,0,0, 4'h0,  4,0,'hA2,0,4'b0000, 1,0,0,1);
    addRow(0,0, 0,0,1,    0,0,0, 4'h0,  3,0,'hA3,0,4'b0000, 0,0,0,1);
    addRow(0,0, 0,0,1,    0,0,0, 4'h0,  2,0,'hA4,0,4'b0000, 0,0,0,1);
    addRow(0,0, 0,0,1,    0,0,0, 4'h0,  1,0,'hAA,0,4'b0000, 0,0,0,1);
    addRow(0,0, 0,0,1,    0,0,0, 4'h0,  0,0,0,0,4'b0000,    0,1,0,1);
    // Flush with data in both sides; pushes in the flush cycle are dropped.
    addRow(0,0, 1,'h01,0, 0,0,0, 4'h0,  1,0,'h01,0,4'b0000, 0,0,0,1);
    addRow(0,0, 1,'h02,0, 0,0,0, 4'h0,  2,0,'h01,0,4'b0000, 0,0,0,1);
    addRow(0,0, 1,'h03,0, 0,0,0, 4'h0,  3,0,'h01,0,4'b0000, 0,0,0,1);
    addRow(0,0, 0,0,0,    1,'h77,0, 4'h0, 3,1,'h01,'h77,4'b0000, 0,0,0,0);
    addRow(0,1, 1,'h99,0, 1,'h88,0, 4'h0, 0,0,0,0,4'b0000,  0,1,0,1);
    addRow(0,0, 0,0,0,    0,0,0, 4'h0,  0,0,0,0,4'b0000,    0,1,0,1);
    // Join change 0->2 with TX data, then TX overflow at zero capacity.
    addRow(0,0, 1,'h05,0, 0,0,0, 4'h0,  1,0,'h05,0,4'b0000, 0,0,0,1);
    addRow(0,0, 1,'h06,0, 0,0,0, 4'h0,  2,0,'h05,0,4'b0000, 0,0,0,1);
    addRow(0,0, 1,'h07,0, 0,0,0, 4'h0,  3,0,'h05,0,4'b0000, 0,0,0,1);
    addRow(2,0, 1,'h09,0, 0,0,0, 4'h0,  0,0,0,0,4'b0000,    1,1,0,1);
    addRow(2,0, 0,0,0,    1,'hB0,0, 4'h0, 0,1,0,'hB0,4'b0000, 1,1,0,0);
    addRow(2,0, 1,'h01,0, 0,0,0, 4'h0,  0,1,0,'hB0,4'b0001, 1,1,0,0);
    addRow(2,0, 0,0,0,    0,0,0, 4'h1,  0,1,0,'hB0,4'b0000, 1,1,0,0);
    addRow(1,0, 0,0,0,    0,0,0, 4'h0,  0,0,0,0,4'b0000,    0,1,1,1);
    addRow(0,0, 0,0,0,    0,0,0, 4'h0,  0,0,0,0,4'b0000,    0,1,0,1);

    // Reset state.
    applyStimulus(1, 0,0, 0,0,0, 0,0,0, 4'h0);
    applyStimulus(1, 0,0, 0,0,0, 0,0,0, 4'h0);
    checkOutput("reset", 0,0,0,0,4'b0000, 0,1,0,1);

    foreach (vecs[i]) begin
      applyStimulus(0, vecs[i].jm, vecs[i].fl, vecs[i].txp, vecs[i].txd, vecs[i].txl,
                    vecs[i].rxp, vecs[i].rxd, vecs[i].rxl, vecs[i].clr);
      checkOutput($sformatf("vec%0d", i), vecs[i].etxl, vecs[i].erxl, vecs[i].etxd,
                  vecs[i].erxd, vecs[i].eerr, vecs[i].etxf, vecs[i].etxe,
                  vecs[i].erxf, vecs[i].erxe);
    end

    // Join TX: eight words fit, RX is zero capacity.
    applyStimulus(0, 1,0, 0,0,0, 0,0,0, 4'h0);
    checkModel("jtx_enter");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1,0, 1,W'(i),0, 0,0,0, 4'h0);
      checkModel($sformatf("jtx_push%0d", i));
    end
    checkValue("jtx_level", W'(tx_level), 8);
    checkValue("jtx_full", W'(tx_full), 1);
    checkValue("jtx_rx_full", W'(rx_full), 1);
    applyStimulus(0, 1,0, 0,0,0, 1,'h5A,0, 4'h0);
    checkValue("jtx_rx_over", W'(err), W'(4'b0100));
    applyStimulus(0, 1,0, 0,0,0, 0,0,0, 4'hF);
    for (int i = 0; i < 8; i++) begin
      checkValue($sformatf("jtx_dout%0d", i), tx_dout, W'(i));
      applyStimulus(0, 1,0, 0,0,1, 0,0,0, 4'h0);
      checkModel($sformatf("jtx_pull%0d", i));
    end

    // Pointer wrap: interleaved push/pull around level 2.
    applyStimulus(0, 0,0, 0,0,0, 0,0,0, 4'h0);
    applyStimulus(0, 0,0, 1,'h100,0, 1,'h300,0, 4'h0);
    applyStimulus(0, 0,0, 1,'h101,0, 1,'h301,0, 4'h0);
    checkModel("wrap_fill");
    for (int k = 0; k < 10; k++) begin
      applyStimulus(0, 0,0, 1,W'(32'h200 + k),0, 1,W'(32'h400 + k),0, 4'h0);
      checkValue($sformatf("wrap_level_push%0d", k), W'(tx_level), 3);
      checkModel($sformatf("wrap_push%0d", k));
      applyStimulus(0, 0,0, 0,0,1, 0,0,1, 4'h0);
      checkModel($sformatf("wrap_pull%0d", k));
    end

    // Reset mid-operation drops pending data.
    applyStimulus(0, 0,0, 1,'hC0,0, 1,'hD0,1, 4'h0);
    applyStimulus(1, 0,0, 1,'hC1,1, 1,'hD1,1, 4'h0);
    checkOutput("mid_reset", 0,0,0,0,4'b0000, 0,1,0,1);

    // Randomized traffic against the model.
    begin
      logic [1:0] rj;
      rj = 2'd0;
      for (int n = 0; n < 1500; n++) begin
        if ($urandom_range(0, 49) == 0) rj = 2'($urandom_range(0, 3));
        applyStimulus($urandom_range(0, 99) == 0, rj, $urandom_range(0, 49) == 0,
                      1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'h0);
        checkModel($sformatf("rand%0d", n));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
